flood_open_engine: RTL

//  Initiator side of the board_cover open interface: given a seed cell, reveals the

---
 rtl/flood_open_engine_if.sv | 34 +++
 rtl/flood_open_engine.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/flood_open_engine_if.sv
// Bundle between the flood-open engine and its neighbours: PLAY control
// (start/abort/status), the board/cover read port and the open handshake
// towards board_cover. master = engine side, slave = environment side.
interface flood_open_engine_if #(
  parameter int X_BITS = 4,
  parameter int Y_BITS = 4
);
  logic                     start;
  logic [X_BITS-1:0]        start_x;
  logic [Y_BITS-1:0]        start_y;
  logic                     abort;
  logic [X_BITS-1:0]        rd_x;
  logic [Y_BITS-1:0]        rd_y;
  logic [4:0]               rd_board;
  logic [1:0]               rd_cover;
  logic                     open_valid;
  logic [X_BITS-1:0]        open_x;
  logic [Y_BITS-1:0]        open_y;
  logic                     open_ready;
  logic                     busy;
  logic                     done;
  logic                     overflow;
  logic [X_BITS+Y_BITS:0]   cells_opened;

  modport master (
    input  start, start_x, start_y, abort, rd_board, rd_cover, open_ready,
    output rd_x, rd_y, open_valid, open_x, open_y, busy, done, overflow, cells_opened
  );

  modport slave (
    output start, start_x, start_y, abort, rd_board, rd_cover, open_ready,
    input  rd_x, rd_y, open_valid, open_x, open_y, busy, done, overflow, cells_opened
  );
endinterface

// File: rtl/flood_open_engine.sv
// Flood-open engine: from a seed cell, walks the connected zero-count region
// breadth-first through a coordinate FIFO and issues one open request per
// covered, unflagged, non-mine cell reached (the numbered border included).
module flood_open_engine #(
  parameter int X_SIZE      = 16,
  parameter int Y_SIZE      = 16,
  parameter int X_BITS      = 4,
  parameter int Y_BITS      = 4,
  parameter int QUEUE_DEPTH = 64
) (
  input  logic clk,
  input  logic reset_n,
  flood_open_engine_if.master bus
);

  localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = X_BITS + Y_BITS + 1;
  localparam logic [X_BITS:0] X_LIM   = (X_BITS+1)'(X_SIZE);
  localparam logic [Y_BITS:0] Y_LIM   = (Y_BITS+1)'(Y_SIZE);
  localparam logic [AW:0]     DEPTH_L = (AW+1)'(QUEUE_DEPTH);

  typedef struct packed {
    logic [Y_BITS-1:0] y;
    logic [X_BITS-1:0] x;
  } coord_t;

  typedef enum logic [2:0] {IDLE, POP, READ, CHECK, OPEN, PUSH, DONE} state_t;

  state_t                   state, state_nx;
  coord_t [QUEUE_DEPTH-1:0] mem;
  logic   [AW-1:0]          wr_ptr, rd_ptr;
  logic   [AW:0]            count;
  logic                     full, empty;

  coord_t                   cur, seed, nbr, push_data;
  logic                     push_req, push_ok, pop_req;
  logic                     seed_ok, nbr_ok;
  logic   [X_BITS:0]        dx, nx_w;
  logic   [Y_BITS:0]        dy, ny_w;
  logic   [2:0]             nbr_idx;
  logic                     zero_cnt;
  logic   [X_BITS-1:0]      rd_x;
  logic   [Y_BITS-1:0]      rd_y;
  logic   [CW-1:0]          cells_opened;
  logic                     overflow;
  logic                     open_valid, xfer;

  assign full       = (count == DEPTH_L);
  assign empty      = (count == '0);
  assign seed.x     = bus.start_x;
  assign seed.y     = bus.start_y;
  assign seed_ok    = ({1'b0, bus.start_x} < X_LIM) && ({1'b0, bus.start_y} < Y_LIM);
  assign open_valid = (state == OPEN);
  assign xfer       = open_valid && bus.open_ready;
  assign push_ok    = push_req && !full;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next state plus FIFO push/pop requests; abort overrides everything
  always_comb begin
    state_nx  = state;
    push_req  = 1'b0;
    push_data = nbr;
    pop_req   = 1'b0;
    if (bus.abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          if (seed_ok) begin
            push_req  = 1'b1;
            push_data = seed;
            state_nx  = POP;
          end else begin
            state_nx  = DONE;
          end
        end
        POP: if (empty) state_nx = DONE;
             else begin
               pop_req  = 1'b1;
               state_nx = READ;
             end
        READ:  state_nx = CHECK;
        // already opened, flagged or mined cells are never opened
        CHECK: state_nx = ((bus.rd_cover != 2'b00) || bus.rd_board[4]) ? POP : OPEN;
        OPEN:  if (bus.open_ready) state_nx = zero_cnt ? PUSH : POP;
        PUSH: begin
          push_req = nbr_ok;
          if (nbr_idx == 3'd7) state_nx = POP;
        end
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Neighbour for the current PUSH index; one extra bit makes x-1 at the
  // left edge and x+1 at the right edge both land out of range (no wrap)
  always_comb begin
    case (nbr_idx)
      3'd0, 3'd3, 3'd5: dx = '1;
      3'd1, 3'd6:       dx = '0;
      default:          dx = (X_BITS+1)'(1);
    endcase
    case (nbr_idx)
      3'd0, 3'd1, 3'd2: dy = '1;
      3'd3, 3'd4:       dy = '0;
      default:          dy = (Y_BITS+1)'(1);
    endcase
    nx_w   = {1'b0, cur.x} + dx;
    ny_w   = {1'b0, cur.y} + dy;
    nbr_ok = (nx_w < X_LIM) && (ny_w < Y_LIM);
    nbr.x  = nx_w[X_BITS-1:0];
    nbr.y  = ny_w[Y_BITS-1:0];
  end

  // FIFO storage; contents are don't-care while count says empty
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers and occupancy; the FSM never pushes and pops together
  always_ff @(posedge clk) begin
    if (!reset_n || bus.abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (push_ok) begin
      wr_ptr <= wr_ptr + AW'(1);
      count  <= count + (AW+1)'(1);
    end else if (pop_req) begin
      rd_ptr <= rd_ptr + AW'(1);
      count  <= count - (AW+1)'(1);
    end
  end

  // Current cell, registered read address, zero-count latch, neighbour index
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur      <= '0;
      rd_x     <= '0;
      rd_y     <= '0;
      zero_cnt <= 1'b0;
      nbr_idx  <= '0;
    end else begin
      if (pop_req)         cur      <= mem[rd_ptr];
      if (state == READ)   {rd_y, rd_x} <= {cur.y, cur.x};
      if (state == CHECK)  zero_cnt <= (bus.rd_board[3:0] == 4'd0);
      nbr_idx <= (state == PUSH) ? nbr_idx + 3'd1 : 3'd0;
    end
  end

  // Open counter and sticky overflow; both survive abort, start clears them
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cells_opened <= '0;
      overflow     <= 1'b0;
    end else if ((state == IDLE) && bus.start && !bus.abort) begin
      cells_opened <= '0;
      overflow     <= 1'b0;
    end else begin
      if (xfer)              cells_opened <= cells_opened + CW'(1);
      if (push_req && full)  overflow     <= 1'b1;
    end
  end

  assign bus.rd_x         = rd_x;
  assign bus.rd_y         = rd_y;
  assign bus.open_valid   = open_valid;
  assign bus.open_x       = cur.x;
  assign bus.open_y       = cur.y;
  assign bus.busy         = (state != IDLE);
  assign bus.done         = (state == DONE);
  assign bus.overflow     = overflow;
  assign bus.cells_opened = cells_opened;

endmodule
